// File: rtl/wash_pkg.sv
// wash_pkg: state encoding, temperature select and default timings for the wash sequencer
package wash_pkg;
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FILL_W  = 4'd1,
    WASH    = 4'd2,
    DRAIN_W = 4'd3,
    FILL_R  = 4'd4,
    RINSE   = 4'd5,
    DRAIN_R = 4'd6,
    SPIN    = 4'd7,
    DONE    = 4'd8,
    FAULT   = 4'd15
  } state_t;
  typedef enum logic [1:0] {COLD = 2'd0, WARM = 2'd1, HOT = 2'd2} temp_t;
  localparam logic [3:0] WASH_TICKS_DEF  = 4'd9;
  localparam logic [3:0] RINSE_TICKS_DEF = 4'd6;
  localparam logic [3:0] SPIN_TICKS_DEF  = 4'd5;
  localparam logic [3:0] FILL_LIMIT_DEF  = 4'd15;
  function automatic temp_t pick_temp(input logic hot, input logic warm);
    return hot ? HOT : warm ? WARM : COLD;
  endfunction
endpackage

// File: rtl/wash_sequencer_stage_timer.sv
// stage_timer: 4-bit loadable down-counter with expiry flag on the last tick
module stage_timer (
  input  logic       clock,
  input  logic       restart,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       enable,
  output logic [3:0] count,
  output logic       expire
);
  always_ff @(posedge clock or posedge restart)
    if (restart) count <= '0;
    else if (load) count <= load_value;
    else if (enable) count <= count - 4'd1;
  assign expire = enable && count == 4'd1;
endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: single-FSM controller sequencing fill, wash, drain, rinse, spin and done
module wash_sequencer
  import wash_pkg::*;
#(
  parameter logic [3:0] WASH_TICKS  = WASH_TICKS_DEF,
  parameter logic [3:0] RINSE_TICKS = RINSE_TICKS_DEF,
  parameter logic [3:0] SPIN_TICKS  = SPIN_TICKS_DEF,
  parameter logic [3:0] FILL_LIMIT  = FILL_LIMIT_DEF
) (
  input  logic       clock,
  input  logic       restart,
  input  logic       start,
  input  logic       full,
  input  logic       empty,
  input  logic       extra_rinse,
  input  logic       hot,
  input  logic       warm,
  input  logic       cold,
  output logic       agitator,
  output logic       spin,
  output logic       pump,
  output logic       alert,
  output logic       cold_valve,
  output logic       hot_valve,
  output logic [3:0] timer,
  output logic [3:0] stage
);
  state_t state, next;
  temp_t temp;
  logic extra, pass, timed, filling, conflict, fill_to, load, expire, unused_cold;
  logic [3:0] fill_cnt, count, load_value;
  // cold is the fallback temperature, so its level never changes the decision
  assign unused_cold = cold;
  assign timed = state inside {WASH, RINSE, SPIN};
  assign filling = state inside {FILL_W, FILL_R};
  assign conflict = full && empty && !(state inside {IDLE, DONE, FAULT});
  assign fill_to = !full && fill_cnt == FILL_LIMIT - 4'd1;
  assign load = next != state && next inside {WASH, RINSE, SPIN};
  assign load_value = next == WASH ? WASH_TICKS : next == RINSE ? RINSE_TICKS : SPIN_TICKS;
  stage_timer u_timer (
    .clock(clock), .restart(restart), .load(load), .load_value(load_value),
    .enable(timed), .count(count), .expire(expire)
  );
  always_comb begin
    next = state;
    if (conflict) next = FAULT;
    else
      case (state)
        IDLE, DONE: next = start ? FILL_W : state;
        FILL_W:     next = full ? WASH : fill_to ? FAULT : FILL_W;
        WASH:       next = expire ? DRAIN_W : WASH;
        DRAIN_W:    next = empty ? FILL_R : DRAIN_W;
        FILL_R:     next = full ? RINSE : fill_to ? FAULT : FILL_R;
        RINSE:      next = expire ? DRAIN_R : RINSE;
        DRAIN_R:    next = !empty ? DRAIN_R : (extra && !pass) ? FILL_R : SPIN;
        SPIN:       next = expire ? DONE : SPIN;
        default:    next = state;
      endcase
  end
  always_ff @(posedge clock or posedge restart)
    if (restart) begin
      state    <= IDLE;
      temp     <= COLD;
      extra    <= 1'b0;
      pass     <= 1'b0;
      fill_cnt <= '0;
    end else begin
      state    <= next;
      fill_cnt <= next != state ? 4'd0 : filling ? fill_cnt + 4'd1 : fill_cnt;
      if (next == FILL_W && state inside {IDLE, DONE}) begin
        temp  <= pick_temp(hot, warm);
        extra <= extra_rinse;
        pass  <= 1'b0;
      end else if (state == DRAIN_R && next == FILL_R) pass <= 1'b1;
    end
  assign hot_valve  = state == FILL_W && temp != COLD;
  assign cold_valve = (state == FILL_W && temp != HOT) || state == FILL_R;
  assign agitator   = state inside {WASH, RINSE};
  assign pump       = state inside {DRAIN_W, DRAIN_R, SPIN};
  assign spin       = state == SPIN;
  assign alert      = state inside {DONE, FAULT};
  assign timer      = timed ? count : 4'd0;
  assign stage      = state;
endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed self-checking bench for the wash sequencer
module tb_wash_sequencer;
  logic clock = 1'b0, restart = 1'b1, start = 1'b0, full = 1'b0, empty = 1'b0;
  logic extra_rinse = 1'b0, hot = 1'b0, warm = 1'b0, cold = 1'b0;
  logic agitator, spin, pump, alert, cold_valve, hot_valve;
  logic [3:0] timer, stage;
  int errors = 0, checks = 0;

  wash_sequencer dut (
    .clock(clock), .restart(restart), .start(start), .full(full), .empty(empty),
    .extra_rinse(extra_rinse), .hot(hot), .warm(warm), .cold(cold),
    .agitator(agitator), .spin(spin), .pump(pump), .alert(alert),
    .cold_valve(cold_valve), .hot_valve(hot_valve), .timer(timer), .stage(stage)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // act order: agitator spin pump alert cold_valve hot_valve
  task automatic expect_all(input string tag, input logic [3:0] st, input logic [5:0] act, input logic [3:0] tm);
    check({tag, ".stage"}, 32'(stage), 32'(st));
    check({tag, ".act"}, 32'({agitator, spin, pump, alert, cold_valve, hot_valve}), 32'(act));
    check({tag, ".timer"}, 32'(timer), 32'(tm));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_fill();
    full = 1'b1;
    tick();
    full = 1'b0;
  endtask

  task automatic do_drain();
    empty = 1'b1;
    tick();
    empty = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_timer(input string tag, input int n);
    for (int t = n - 1; t >= 1; t--) begin
      tick();
      check(tag, 32'(timer), 32'(t));
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    #1;
    check("restart.stage", 32'(stage), 32'd0);
    tick();
    restart = 1'b0;
  endtask

  initial begin
    ticks(2);
    restart = 1'b0;
    expect_all("reset", 4'd0, 6'b000000, 4'd0);
    // nominal warm cycle
    warm = 1'b1;
    do_start();
    warm = 1'b0;
    expect_all("fill_w_warm", 4'd1, 6'b000011, 4'd0);
    ticks(2);
    do_fill();
    expect_all("wash", 4'd2, 6'b100000, 4'd9);
    run_timer("wash.timer", 9);
    tick();
    expect_all("drain_w", 4'd3, 6'b001000, 4'd0);
    do_drain();
    expect_all("fill_r", 4'd4, 6'b000010, 4'd0);
    do_fill();
    expect_all("rinse", 4'd5, 6'b100000, 4'd6);
    run_timer("rinse.timer", 6);
    tick();
    expect_all("drain_r", 4'd6, 6'b001000, 4'd0);
    do_drain();
    expect_all("spin", 4'd7, 6'b011000, 4'd5);
    run_timer("spin.timer", 5);
    tick();
    expect_all("done", 4'd8, 6'b000100, 4'd0);
    // extra rinse, hot, inputs cleared after latching
    extra_rinse = 1'b1;
    hot = 1'b1;
    do_start();
    extra_rinse = 1'b0;
    hot = 1'b0;
    expect_all("fill_w_hot", 4'd1, 6'b000001, 4'd0);
    do_fill();
    ticks(9);
    check("xr.drain_w", 32'(stage), 32'd3);
    do_drain();
    do_fill();
    ticks(6);
    check("xr.drain_r1", 32'(stage), 32'd6);
    do_drain();
    expect_all("xr.fill_r2", 4'd4, 6'b000010, 4'd0);
    do_fill();
    check("xr.rinse2", 32'(stage), 32'd5);
    ticks(6);
    do_drain();
    check("xr.spin", 32'(stage), 32'd7);
    ticks(5);
    check("xr.done", 32'(stage), 32'd8);
    // temperature priority, hot toggled mid-wash
    hot = 1'b1; warm = 1'b1; cold = 1'b1;
    do_start();
    hot = 1'b0; warm = 1'b0; cold = 1'b0;
    expect_all("prio_hot", 4'd1, 6'b000001, 4'd0);
    do_fill();
    hot = 1'b1;
    tick();
    expect_all("wash_hot_toggle", 4'd2, 6'b100000, 4'd8);
    hot = 1'b0;
    ticks(8);
    check("prio.drain_w", 32'(stage), 32'd3);
    do_drain();
    do_fill();
    ticks(6);
    do_drain();
    ticks(5);
    check("prio.done", 32'(stage), 32'd8);
    // no select gives cold; full never arrives -> fill timeout
    do_start();
    expect_all("fill_w_cold", 4'd1, 6'b000010, 4'd0);
    ticks(14);
    check("timeout.cycle15", 32'(stage), 32'd1);
    tick();
    expect_all("fault", 4'd15, 6'b000100, 4'd0);
    do_start();
    check("fault.start_ignored", 32'(stage), 32'd15);
    pulse_restart();
    // full on the limit cycle wins over the timeout
    do_start();
    ticks(14);
    do_fill();
    check("limit_full", 32'(stage), 32'd2);
    // sensor conflict in rinse
    ticks(9);
    do_drain();
    do_fill();
    ticks(2);
    full = 1'b1; empty = 1'b1;
    tick();
    full = 1'b0; empty = 1'b0;
    expect_all("conflict", 4'd15, 6'b000100, 4'd0);
    pulse_restart();
    // asynchronous reset mid-wash
    do_start();
    do_fill();
    ticks(5);
    check("wash.t4", 32'(timer), 32'd4);
    #2;
    restart = 1'b1;
    #1;
    expect_all("async_reset", 4'd0, 6'b000000, 4'd0);
    tick();
    restart = 1'b0;
    do_start();
    check("restart.fill_w", 32'(stage), 32'd1);
    do_fill();
    expect_all("restart.wash", 4'd2, 6'b100000, 4'd9);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Single-FSM controller that sequences one complete laundry cycle (fill, wash, drain, rinse ×1 or ×2, spin, done) for the washing-machine datapath. It drives the valves, pump, agitator, spin motor and alert, and generates the stage and timer display codes. It runs from one internal stage timer. It sits between the machine's sensor and switch inputs and the actuator and display outputs.

## Interface
- WASH_TICKS, 9, clock cycles spent in WASH
- RINSE_TICKS, 6, clock cycles spent in each RINSE pass
- SPIN_TICKS, 5, clock cycles spent in SPIN
- FILL_LIMIT, 15, maximum cycles in any FILL state before FAULT
- All TICKS values are 1..15; FILL_LIMIT is 1..15.

Ports:
- clock  in  1  system clock, rising edge
- restart  in  1  asynchronous active-high reset
- start  in  1  begin cycle (level, sampled)
- full  in  1  tub-full sensor
- empty  in  1  tub-empty sensor
- extra_rinse  in  1  request second rinse pass
- hot, warm, cold  in  1 each  wash temperature select
- agitator, spin, pump, alert  out  1 each  actuators
- cold_valve, hot_valve  out  1 each  water valves
- timer  out  4  remaining ticks of the current timed stage, else 0
- stage  out  4  current stage code

## Operation
- States and stage codes:
  - IDLE = 0
  - FILL_W = 1
  - WASH = 2
  - DRAIN_W = 3
  - FILL_R = 4
  - RINSE = 5
  - DRAIN_R = 6
  - SPIN = 7
  - DONE = 8
  - FAULT = 15
- Transitions:
  - IDLE→FILL_W on start.
  - FILL_W→WASH on full.
  - WASH→DRAIN_W on timer expiry.
  - DRAIN_W→FILL_R on empty.
  - FILL_R→RINSE on full.
  - RINSE→DRAIN_R on expiry.
  - DRAIN_R→FILL_R on empty if a second pass is pending; otherwise DRAIN_R→SPIN on empty.
  - SPIN→DONE on expiry.
  - DONE→FILL_W on start.
- Configuration is latched on the IDLE→FILL_W and DONE→FILL_W transitions and held for the whole cycle; input changes mid-cycle are ignored.
  - Temperature is latched with priority hot > warm > cold; if none is set, cold is used.
  - extra_rinse is latched, and the pass counter is cleared.
- Outputs (Moore, decoded from the registered state):
  - FILL_W: valves per the latched temperature. Hot opens hot_valve only, warm opens both valves, cold opens cold_valve only.
  - FILL_R: cold_valve only (cold override).
  - WASH and RINSE: agitator.
  - DRAIN_W and DRAIN_R: pump.
  - SPIN: spin and pump.
  - DONE and FAULT: alert.
  - Every other output is 0 in each state.
- FAULT conditions:
  - The fill counter reaches FILL_LIMIT in FILL_W or FILL_R.
  - full and empty are both high in any state other than IDLE, DONE or FAULT.
- FAULT exits only on restart.
- start outside IDLE and DONE is ignored.
- In FILL states, full is tested before the fill limit; full on the limit cycle goes to the next state, not to FAULT.

## Timing
- Reset (restart high, asynchronous): state=IDLE, all actuator outputs 0, alert 0, stage=0, timer=0, latches cleared. Reset asserted mid-cycle closes the valves immediately, without waiting for a clock edge.
- Latency: an input sampled at edge N changes state, and therefore outputs, at edge N. Outputs are valid in the cycle following the edge; there is no combinational input→output path.
- Timed states:
  - On entry the counter loads TICKS, so timer shows TICKS in the first cycle of the state.
  - The counter decrements every cycle.
  - When the counter equals 1, the next edge leaves the state. Each timed state therefore lasts exactly TICKS cycles, with timer sequence TICKS, TICKS-1, …, 1.
- Fill counter: cleared on entry to a FILL state and incremented every cycle in it. FAULT is entered on the edge where the count is already FILL_LIMIT-1 and full is low. A FILL state therefore lasts at most FILL_LIMIT cycles.
- timer reads 0 in every non-timed state.

## Structure
- Package wash_pkg holds:
  - the stage/state encoding constants;
  - the default TICKS and FILL_LIMIT values;
  - the temperature-select encoding (COLD, WARM, HOT).
- Sub-module stage_timer:
  - 4-bit loadable down-counter.
  - Inputs: clock, restart, load, load_value, enable.
  - Outputs: count, expire (count==1 and enable).
- The fill counter and the FSM stay in wash_sequencer.

## Test plan
- Nominal warm cycle: reset, set warm=1, pulse start; raise full after 3 cycles; raise empty after drain. Required: stage 0→1→2→3→4→5→6→7→8; both valves open in stage 1; cold_valve only in stage 4; timer 9..1 in WASH, 6..1 in RINSE, 5..1 in SPIN; alert=1 in DONE.
- Extra rinse: extra_rinse=1 at start, then cleared mid-cycle. Required: stage sequence contains 4,5,6,4,5,6 before 7.
- Temperature priority: hot=warm=cold=1 at start gives hot_valve only in FILL_W. No select set gives cold_valve only. Toggling hot during WASH changes nothing.
- Fill timeout: start with full never asserted. Required: FAULT (stage=15, alert=1, valves 0) after exactly 15 cycles in FILL_W. start is then ignored; restart returns to stage=0.
- Sensor conflict: full=empty=1 during RINSE → FAULT on the next edge.
- Reset mid-WASH with timer=4: outputs drop to 0 asynchronously; timer=0, stage=0. The next start begins a fresh cycle with timer reloaded to 9.
